// File: rtl/adder_11bit_inverter_pkg.sv
// Shared types and sizing for the bit-serial adder inverter (sum - b -> a).
// The top and its testbench both import this package.
package adder_11bit_inverter_pkg;

    localparam int W_DEF = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Enough bits to count W+1 serial steps (0..W).
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_width(W_DEF);

endpackage

// File: rtl/adder_11bit_inverter_full_adder.sv
// Single-bit full adder cell.
// The inverter uses it as a one-bit subtractor by feeding ~b with carry-in 1.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/adder_11bit_inverter.sv
// Bit-serial inverse of the W-bit ripple adder: recovers a = sum - b one bit per clock.
// A single full_adder cell does the subtraction; err flags results outside 0..2^W-1.
module adder_11bit_inverter
    import adder_11bit_inverter_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W:0]   sum_in,
    input  logic [W-1:0] b_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] a_out,
    output logic         err
);

    localparam int CW = cnt_width(W);

    // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
    // in_ready and out_valid are registered, so neither depends combinationally on the
    // opposite side's valid/ready; the sender must hold its data until the transfer.

    state_t        state;
    logic [W:0]    sum_sh;
    logic [W:0]    b_sh;
    logic [W:0]    diff;
    logic [CW-1:0] cnt;
    logic          carry;

    logic fa_s;
    logic fa_cout;

    full_adder u_cell (
        .a    (sum_sh[0]),
        .b    (~b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_out     <= '0;
            err       <= 1'b0;
            sum_sh    <= '0;
            b_sh      <= '0;
            diff      <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sum_sh   <= sum_in;
                        b_sh     <= {1'b0, b_in};
                        carry    <= 1'b1;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end

                SHIFT: begin
                    // LSB-first: each difference bit enters at the top and walks down.
                    diff   <= {fa_s, diff[W:1]};
                    sum_sh <= sum_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= fa_cout;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(W)) begin
                        state <= DONE;
                    end
                end

                DONE: begin
                    if (!out_valid) begin
                        // A cleared final carry is a borrow (sum < b); diff[W] means > 2^W-1.
                        out_valid <= 1'b1;
                        a_out     <= diff[W-1:0];
                        err       <= ~carry | diff[W];
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_11bit_inverter.sv
// Self-checking bench for adder_11bit_inverter: directed corner cases, backpressure,
// mid-operation reset and random operations, with an expected-result queue.
module tb_adder_11bit_inverter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] sum_in;
    logic [10:0] b_in;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] a_out;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Each entry is {err, a_out} for one accepted operation.
    logic [11:0] exp_q[$];

    adder_11bit_inverter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_in    (sum_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_out     (a_out),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] model(input logic [11:0] s, input logic [10:0] b);
        int d;
        logic e;
        d = int'(s) - int'(b);
        e = (d < 0) || (d > 2047);
        return {e, d[10:0]};
    endfunction

    task automatic send(input logic [11:0] s, input logic [10:0] b);
        int n = 0;
        sum_in   = s;
        b_in     = b;
        in_valid = 1'b1;
        while (!in_ready && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!in_ready) begin
            $display("FAIL accept_timeout: in_ready=0 after %0d cycles, required 1", n);
            errors++;
        end else begin
            exp_q.push_back(model(s, b));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic recv(input int hold, input string tag);
        int n = 0;
        logic [11:0] snap;
        logic [11:0] exp;
        out_ready = 1'b0;
        while (!out_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!out_valid) begin
            $display("FAIL %s_timeout: out_valid=0 after %0d cycles, required 1", tag, n);
            errors++;
            exp_q.delete();
            return;
        end
        snap = {err, a_out};
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || {err, a_out} !== snap || in_ready !== 1'b0) begin
                $display("FAIL %s_hold: cycle %0d out_valid=%b err/a=%h in_ready=%b, required 1 %h 0",
                         tag, i, out_valid, {err, a_out}, in_ready, snap);
                errors++;
            end
        end
        checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s_unexpected: result %h with empty expected queue", tag, {err, a_out});
            errors++;
        end else begin
            exp = exp_q.pop_front();
            if ({err, a_out} !== exp) begin
                $display("FAIL %s_result: err=%b a_out=%h, required err=%b a_out=%h",
                         tag, err, a_out, exp[11], exp[10:0]);
                errors++;
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL %s_release: out_valid=%b in_ready=%b, required 0 1", tag, out_valid, in_ready);
            errors++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
            errors++;
        end
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL reset_out_valid: got %b, required 0", out_valid);
            errors++;
        end
        checks++;
        if (a_out !== 11'd0 || err !== 1'b0) begin
            $display("FAIL reset_outputs: a_out=%h err=%b, required 000 0", a_out, err);
            errors++;
        end
    endtask

    task automatic test_latency(input logic [11:0] s, input logic [10:0] b, input string tag);
        int n = 0;
        send(s, b);
        while (!out_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != 13) begin
            $display("FAIL %s_latency: out_valid after %0d cycles, required 13", tag, n);
            errors++;
        end
        recv(0, tag);
    endtask

    task automatic test_corners();
        test_latency(12'd255, 11'd100, "basic");
        test_latency(12'd4094, 11'd2047, "max_legal");
        test_latency(12'd5, 11'd6, "borrow");
        test_latency(12'd4095, 11'd0, "overflow");
        test_latency(12'd2048, 11'd1, "edge_2047");
        test_latency(12'd2048, 11'd0, "edge_2048");
    endtask

    task automatic test_backpressure();
        send(12'd777, 11'd555);
        recv(5, "bp");
        send(12'd1000, 11'd1);
        recv(0, "bp_second");
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        send(12'd500, 11'd7);
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || a_out !== 11'd0 || err !== 1'b0) begin
            $display("FAIL midreset_state: out_valid=%b in_ready=%b a_out=%h err=%b, required 0 1 000 0",
                     out_valid, in_ready, a_out, err);
            errors++;
        end
        out_ready = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        out_ready = 1'b0;
        checks++;
        if (seen != 0) begin
            $display("FAIL midreset_ghost: out_valid high %0d cycles after abort, required 0", seen);
            errors++;
        end
        send(12'd300, 11'd44);
        recv(0, "after_reset");
    endtask

    task automatic test_random();
        logic [11:0] s;
        logic [10:0] b;
        for (int i = 0; i < 16; i++) begin
            s = 12'($urandom_range(0, 4095));
            b = 11'($urandom_range(0, 2047));
            send(s, b);
            recv($urandom_range(0, 3), "random");
        end
    endtask

    task automatic test_back_to_back();
        send(12'd1, 11'd1);
        recv(0, "b2b_zero");
        send(12'd2047, 11'd2047);
        recv(0, "b2b_same");
        send(12'd0, 11'd2047);
        recv(0, "b2b_min");
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sum_in    = '0;
        b_in      = '0;
        #1;
        test_reset();
        test_corners();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL leftover: %0d expected results never produced, required 0", exp_q.size());
            errors++;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
